set_job_queue: RTL and testbench
================================

Name: set_job_queue

Overview:
- Upstream job front-end for the SET engine.
- Accepts set-membership jobs (central, radius, mode) over a valid/ready interface and buffers them in a command FIFO.
- Issues one job at a time to SET using the en/busy/valid protocol, then captures the candidate count into a result FIFO drained over valid/ready.
- Decouples the host from SET latency and allows back-to-back job submission.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- RES_DEPTH, 4, result FIFO entries; power of 2, ≥2.
- TIMEOUT_CYC, 512, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-low
- cmd_valid_i  in  1  host job valid
- cmd_ready_o  out  1  command FIFO not full
- cmd_central_i  in  24  three packed 4-bit (x,y) centres
- cmd_radius_i  in  12  three packed 4-bit radii
- cmd_mode_i  in  2  set-operation mode
- set_en_o  out  1  one-cycle start pulse to SET
- set_central_o  out  24  job centre to SET
- set_radius_o  out  12  job radius to SET
- set_mode_o  out  2  job mode to SET
- set_busy_i  in  1  SET busy
- set_valid_i  in  1  SET result valid (one-cycle pulse)
- set_candidate_i  in  8  SET candidate count
- res_valid_o  out  1  result FIFO not empty
- res_ready_i  in  1  host accepts result
- res_candidate_o  out  8  head result
- idle_o  out  1  both FIFOs empty and FSM in IDLE

Behaviour:
- Reset (rst_i=0 at clock edge): FIFOs emptied, FSM to IDLE.
  - Outputs during and after reset: set_en_o=0, set_*_o=0, cmd_ready_o=1, res_valid_o=0, res_candidate_o=0, idle_o=1.
  - Reset mid-job abandons the job; any later set_valid_i is ignored while FSM is IDLE.
- Command push when cmd_valid_i && cmd_ready_o. Result pop when res_valid_o && res_ready_i.
- Simultaneous push and pop on either FIFO is legal in any state, including full and empty.
  - Full FIFO with simultaneous pop and push: no push allowed, because cmd_ready_o is already 0 (registered full flag).
- set_central_o/set_radius_o/set_mode_o show the command FIFO head. They are zeroed when the FIFO is empty. They are held stable from ISSUE until the job's result is captured.
- FSM states:
  - IDLE: go to ISSUE when command FIFO non-empty, !set_busy_i, and result FIFO has ≥1 free slot. The free-slot count includes the current-cycle pop; this is the credit rule, so a result can never be dropped.
  - ISSUE: set_en_o=1 for exactly this cycle. Next state WAIT.
  - WAIT: on set_valid_i, write set_candidate_i into the result FIFO, pop the command FIFO head, go to IDLE.
    - A valid arriving in the same cycle as a host pop of a full result FIFO is accepted.
- Job latency:
  - Command accepted into an empty queue with SET idle → set_en_o asserts 2 cycles later (1 cycle FIFO write, 1 cycle IDLE decision).
  - set_valid_i → res_valid_o high the next cycle.
- Minimum spacing between consecutive set_en_o pulses is 3 cycles (ISSUE, WAIT ≥1, IDLE).
- set_valid_i outside WAIT is ignored.
- Results are delivered in command order. No arithmetic beyond FIFO pointers (log2(DEPTH)+1 bits, wrap-around via MSB).

Optional Feature:
- SET_JOB_QUEUE_TIMEOUT_EN defined:
  - Adds port err_o (out, 1) and a WAIT-cycle counter that resets on entry to WAIT.
  - When the counter reaches TIMEOUT_CYC with no set_valid_i: push candidate 8'hFF, pop the command, pulse err_o for 1 cycle, return to IDLE.
  - If set_valid_i coincides with the timeout cycle, the valid result wins.
- Undefined: no counter and no err_o port; WAIT waits indefinitely.

Decomposition:
- def.v holds the width constants: CENTRAL_SZ=24, RADIUS_SZ=12, MODE_SZ=2, CAND_SZ=8, plus FSM state encodings for IDLE/ISSUE/WAIT.
- One sub-module, set_sync_fifo, parameterised by WIDTH and DEPTH, with registered full/empty. It is instantiated as the command FIFO (38 bits) and the result FIFO (8 bits).

Test Plan:
- Single job: push central=24'h123456, radius=12'h333, mode=2 → set_en_o pulses at cycle +2 with those values; SET model returns 8'd17 after 10 cycles → res_candidate_o=17, res_valid_o=1 the next cycle, idle_o=1 after pop.
- Fill: push 5 jobs with SET held busy → cmd_ready_o=0 after the 4th push; 5th accepted only after the first job completes; results return in order.
- Backpressure: res_ready_i=0 with 4 results queued → no set_en_o issued; one pop → next job issues; no result lost.
- Spurious set_valid_i while IDLE, and set_busy_i=1 in IDLE → no capture, no issue.
- Reset asserted in WAIT → all outputs return to reset values; a later set_valid_i produces no result.
- With SET_JOB_QUEUE_TIMEOUT_EN and TIMEOUT_CYC=16, SET never responds → err_o pulses 16 cycles after WAIT entry; result 8'hFF delivered; next job issues.

Source files
------------

// File: rtl/set_job_queue_pkg.sv
// Shared widths, job record and FSM encoding for the SET job queue.
package set_job_queue_pkg;

    localparam int CENTRAL_SZ = 24;
    localparam int RADIUS_SZ  = 12;
    localparam int MODE_SZ    = 2;
    localparam int CAND_SZ    = 8;
    localparam int CMD_SZ     = CENTRAL_SZ + RADIUS_SZ + MODE_SZ;

    // One queued job as stored in the command FIFO
    typedef struct packed {
        logic [CENTRAL_SZ-1:0] central;
        logic [RADIUS_SZ-1:0]  radius;
        logic [MODE_SZ-1:0]    mode;
    } job_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/set_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and an asynchronously
// read head, so a written word is visible on data_o the following cycle.
// Pointers carry one extra MSB so full and empty are told apart by wrap.
module set_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // A push into a full FIFO or a pop from an empty one is dropped here
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next pointers and the flags they imply, so the flags can be registered
    always_comb begin
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    // Pointer and flag registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the flags gate them
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/set_job_queue.sv
// Job front-end for the SET engine: buffers host jobs, issues them one at a
// time with the en/busy/valid handshake and queues candidate counts back.
// Optional watchdog: define SET_JOB_QUEUE_TIMEOUT_EN to add err_o and a
// WAIT-state timeout that returns candidate 8'hFF for an unanswered job.
module set_job_queue
    import set_job_queue_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int RES_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [CENTRAL_SZ-1:0] cmd_central_i,
    input  logic [RADIUS_SZ-1:0]  cmd_radius_i,
    input  logic [MODE_SZ-1:0]    cmd_mode_i,
    output logic                  set_en_o,
    output logic [CENTRAL_SZ-1:0] set_central_o,
    output logic [RADIUS_SZ-1:0]  set_radius_o,
    output logic [MODE_SZ-1:0]    set_mode_o,
    input  logic                  set_busy_i,
    input  logic                  set_valid_i,
    input  logic [CAND_SZ-1:0]    set_candidate_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [CAND_SZ-1:0]    res_candidate_o,
    output logic                  idle_o
`ifdef SET_JOB_QUEUE_TIMEOUT_EN
    ,
    output logic                  err_o
`endif
);

    state_e             state_q, state_d;
    job_t               cmd_in, cmd_head, job_out;
    logic               cmd_full, cmd_empty;
    logic               res_full, res_empty;
    logic               res_pop, issue_ok, job_done;
    logic [CAND_SZ-1:0] res_din, res_head;

    assign cmd_in = {cmd_central_i, cmd_radius_i, cmd_mode_i};

    set_sync_fifo #(.WIDTH(CMD_SZ), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i && !cmd_full),
        .data_i  (cmd_in),
        .pop_i   (job_done),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    set_sync_fifo #(.WIDTH(CAND_SZ), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (job_done),
        .data_i  (res_din),
        .pop_i   (res_pop),
        .data_o  (res_head),
        .full_o  (res_full),
        .empty_o (res_empty)
    );

    assign res_pop = res_ready_i && !res_empty;

    // Issue only with a reserved result slot (counting this cycle's pop),
    // so the eventual result can always be written.
    assign issue_ok = !cmd_empty && !set_busy_i && (!res_full || res_pop);

`ifdef SET_JOB_QUEUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] wait_cnt_q;
    logic          timeout_hit;

    // Counts WAIT cycles; held at zero elsewhere so it restarts on WAIT entry
    always_ff @(posedge clk_i) begin
        if (!rst_i || state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_ONE;
        end
    end

    // A real result in the timeout cycle takes precedence over the watchdog
    assign timeout_hit = (state_q == ST_WAIT) && !set_valid_i &&
                         (wait_cnt_q == CNT_LIMIT);
    assign job_done    = (state_q == ST_WAIT) && (set_valid_i || timeout_hit);
    assign res_din     = set_valid_i ? set_candidate_i : {CAND_SZ{1'b1}};
`else
    // Without the watchdog the limit has no effect
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign job_done = (state_q == ST_WAIT) && set_valid_i;
    assign res_din  = set_candidate_i;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue_ok) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (job_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: start pulse for exactly the ISSUE cycle
    always_comb begin
        set_en_o = (state_q == ST_ISSUE);
`ifdef SET_JOB_QUEUE_TIMEOUT_EN
        err_o    = timeout_hit;
`endif
    end

    // The head job stays put until its result is captured, so the SET
    // operands are stable for the whole job.
    assign job_out         = cmd_empty ? '0 : cmd_head;
    assign set_central_o   = job_out.central;
    assign set_radius_o    = job_out.radius;
    assign set_mode_o      = job_out.mode;

    assign cmd_ready_o     = !cmd_full;
    assign res_valid_o     = !res_empty;
    assign res_candidate_o = res_empty ? '0 : res_head;
    assign idle_o          = cmd_empty && res_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_set_job_queue.sv
// Directed and random checks of set_job_queue against a queue-level model.
module tb_set_job_queue;

    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
    } tb_job_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [23:0] cmd_central_i;
    logic [11:0] cmd_radius_i;
    logic [1:0]  cmd_mode_i;
    logic        set_en_o;
    logic [23:0] set_central_o;
    logic [11:0] set_radius_o;
    logic [1:0]  set_mode_o;
    logic        set_busy_i;
    logic        set_valid_i;
    logic [7:0]  set_candidate_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [7:0]  res_candidate_o;
    logic        idle_o;
`ifdef SET_JOB_QUEUE_TIMEOUT_EN
    logic        err_o;
`endif

    always #5 clk = ~clk;

    set_job_queue #(
        .CMD_DEPTH   (CMD_DEPTH),
        .RES_DEPTH   (RES_DEPTH),
        .TIMEOUT_CYC (512)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_central_i   (cmd_central_i),
        .cmd_radius_i    (cmd_radius_i),
        .cmd_mode_i      (cmd_mode_i),
        .set_en_o        (set_en_o),
        .set_central_o   (set_central_o),
        .set_radius_o    (set_radius_o),
        .set_mode_o      (set_mode_o),
        .set_busy_i      (set_busy_i),
        .set_valid_i     (set_valid_i),
        .set_candidate_i (set_candidate_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_candidate_o (res_candidate_o),
        .idle_o          (idle_o)
`ifdef SET_JOB_QUEUE_TIMEOUT_EN
        ,
        .err_o           (err_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: jobs held by the queue, results awaiting the host,
    // and where the single outstanding SET job is in its handshake.
    tb_job_t    exp_cmd[$];
    logic [7:0] exp_res[$];
    bit waiting    = 1'b0;
    bit cur_issue  = 1'b0;
    bit prev_idle  = 1'b1;
    bit prev_busy  = 1'b0;
    bit last_push  = 1'b0;
    int countdown  = 0;
    bit auto_set   = 1'b0;
    bit force_busy = 1'b0;
    bit rand_busy  = 1'b0;
    bit spurious   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tb_job_t rjob();
        tb_job_t j;
        j.c = 24'($urandom);
        j.r = 12'($urandom);
        j.m = 2'($urandom);
        return j;
    endfunction

    function automatic logic [7:0] cand_of(input tb_job_t j);
        return j.c[7:0] ^ j.c[23:16] ^ j.r[7:0] ^ {6'd0, j.m} ^ 8'h5A;
    endfunction

    task automatic check_outputs();
        tb_job_t h;
        logic    legal;
        legal = (exp_cmd.size() > 0) && prev_idle && !prev_busy && (exp_res.size() < RES_DEPTH);
        if (exp_cmd.size() > 0) h = exp_cmd[0];
        else h = '{c: 24'd0, r: 12'd0, m: 2'd0};
        chk("cmd_ready", cmd_ready_o, exp_cmd.size() < CMD_DEPTH);
        chk("res_valid", res_valid_o, exp_res.size() > 0);
        chk("res_cand", res_candidate_o, (exp_res.size() > 0) ? exp_res[0] : 8'd0);
        chk("idle", idle_o, (exp_cmd.size() == 0) && (exp_res.size() == 0));
        chk("set_job", {set_central_o, set_radius_o, set_mode_o}, {h.c, h.r, h.m});
        chk("en_rule", set_en_o && !legal, 1'b0);
    endtask

    // Behavioural SET engine: answers each start after a random delay
    task automatic drive_set();
        set_valid_i     = 1'b0;
        set_candidate_i = 8'($urandom);
        if (cur_issue) begin
            countdown = int'($urandom_range(0, 5));
            if (spurious && $urandom_range(0, 3) == 0) set_valid_i = 1'b1;
        end else if (waiting) begin
            if (countdown == 0) begin
                set_valid_i = 1'b1;
                if (exp_cmd.size() > 0) set_candidate_i = cand_of(exp_cmd[0]);
            end else begin
                countdown--;
            end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
            set_valid_i = 1'b1;
        end
        set_busy_i = force_busy || cur_issue || waiting || (rand_busy && $urandom_range(0, 3) == 0);
    endtask

    // Advance one clock: account for this cycle's handshakes, then check
    task automatic tick();
        bit         in_rst, do_push, do_pop, do_cmp;
        tb_job_t    j;
        logic [7:0] cand;
        in_rst    = !rst_i;
        do_push   = !in_rst && cmd_valid_i && (exp_cmd.size() < CMD_DEPTH);
        do_pop    = !in_rst && res_ready_i && (exp_res.size() > 0);
        do_cmp    = !in_rst && set_valid_i && waiting;
        j         = '{c: cmd_central_i, r: cmd_radius_i, m: cmd_mode_i};
        cand      = set_candidate_i;
        prev_busy = set_busy_i;
        prev_idle = !waiting && !cur_issue;
        last_push = do_push;
        @(posedge clk);
        if (in_rst) begin
            exp_cmd.delete();
            exp_res.delete();
            waiting   = 1'b0;
            cur_issue = 1'b0;
            prev_idle = 1'b1;
        end else begin
            if (do_pop) void'(exp_res.pop_front());
            if (do_cmp) begin
                exp_res.push_back(cand);
                if (exp_cmd.size() > 0) void'(exp_cmd.pop_front());
            end
            if (do_push) exp_cmd.push_back(j);
            waiting = (waiting || cur_issue) && !do_cmp;
        end
        @(negedge clk);
        check_outputs();
        cur_issue = set_en_o;
        if (auto_set) drive_set();
    endtask

    task automatic send(input tb_job_t j, input int maxc);
        bit ok;
        ok = 1'b0;
        cmd_central_i = j.c;
        cmd_radius_i  = j.r;
        cmd_mode_i    = j.m;
        cmd_valid_i   = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (last_push) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid_i = 1'b0;
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic drain(input int maxc);
        res_ready_i = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            if (exp_cmd.size() == 0 && exp_res.size() == 0) break;
            tick();
        end
        res_ready_i = 1'b0;
        tick();
        chk("drain_idle", idle_o, 1'b1);
    endtask

    initial begin
        tb_job_t j5;
        rst_i = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_central_i = '0;
        cmd_radius_i = '0;
        cmd_mode_i = '0;
        set_busy_i = 1'b0;
        set_valid_i = 1'b0;
        set_candidate_i = '0;
        res_ready_i = 1'b0;

        // Reset state
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        chk("rst_en", set_en_o, 1'b0);
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_cand", res_candidate_o, 8'd0);
        chk("rst_idle", idle_o, 1'b1);

        // Single job with fixed latency checks
        cmd_central_i = 24'h123456;
        cmd_radius_i  = 12'h333;
        cmd_mode_i    = 2'd2;
        cmd_valid_i   = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        chk("t1_en_plus1", set_en_o, 1'b0);
        tick();
        chk("t1_en_plus2", set_en_o, 1'b1);
        chk("t1_central", set_central_o, 24'h123456);
        chk("t1_radius", set_radius_o, 12'h333);
        chk("t1_mode", set_mode_o, 2'd2);
        repeat (10) tick();
        set_valid_i = 1'b1;
        set_candidate_i = 8'd17;
        tick();
        set_valid_i = 1'b0;
        chk("t1_res_valid", res_valid_o, 1'b1);
        chk("t1_res_cand", res_candidate_o, 8'd17);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("t1_idle", idle_o, 1'b1);

        // Fill the command FIFO while SET is busy
        auto_set = 1'b1;
        force_busy = 1'b1;
        set_busy_i = 1'b1;
        for (int i = 0; i < CMD_DEPTH; i++) send(rjob(), 20);
        chk("fill_ready_low", cmd_ready_o, 1'b0);
        j5 = rjob();
        cmd_central_i = j5.c;
        cmd_radius_i  = j5.r;
        cmd_mode_i    = j5.m;
        cmd_valid_i   = 1'b1;
        repeat (4) begin
            tick();
            chk("fill_no_issue", set_en_o, 1'b0);
        end
        force_busy = 1'b0;
        send(j5, 200);
        drain(400);

        // Result backpressure and the pop-credit issue
        res_ready_i = 1'b0;
        for (int i = 0; i < RES_DEPTH + 1; i++) send(rjob(), 60);
        for (int i = 0; i < 200; i++) begin
            if (exp_res.size() == RES_DEPTH) break;
            tick();
        end
        repeat (8) begin
            tick();
            chk("bp_no_issue", set_en_o, 1'b0);
        end
        chk("bp_res_valid", res_valid_o, 1'b1);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("bp_credit_issue", set_en_o, 1'b1);
        drain(400);

        // Spurious valid in IDLE, then busy holding off an issue
        auto_set = 1'b0;
        set_busy_i = 1'b0;
        set_valid_i = 1'b1;
        set_candidate_i = 8'd99;
        repeat (3) begin
            tick();
            chk("spur_no_capture", res_valid_o, 1'b0);
        end
        set_valid_i = 1'b0;
        set_busy_i = 1'b1;
        send(rjob(), 5);
        repeat (6) begin
            tick();
            chk("busy_no_issue", set_en_o, 1'b0);
        end
        set_busy_i = 1'b0;
        tick();
        chk("busy_release_issue", set_en_o, 1'b1);
        tick();
        set_valid_i = 1'b1;
        set_candidate_i = 8'h42;
        tick();
        set_valid_i = 1'b0;
        chk("t4_result", res_candidate_o, 8'h42);
        drain(10);

        // Reset while a job is in WAIT
        send(rjob(), 5);
        for (int i = 0; i < 10; i++) begin
            if (set_en_o) break;
            tick();
        end
        chk("t5_en_seen", set_en_o, 1'b1);
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        chk("t5_rst_en", set_en_o, 1'b0);
        chk("t5_rst_job", {set_central_o, set_radius_o, set_mode_o}, 38'd0);
        chk("t5_rst_ready", cmd_ready_o, 1'b1);
        chk("t5_rst_res_valid", res_valid_o, 1'b0);
        chk("t5_rst_cand", res_candidate_o, 8'd0);
        chk("t5_rst_idle", idle_o, 1'b1);
        rst_i = 1'b1;
        tick();
        set_valid_i = 1'b1;
        set_candidate_i = 8'd77;
        tick();
        set_valid_i = 1'b0;
        tick();
        chk("t5_late_valid", res_valid_o, 1'b0);
        chk("t5_idle", idle_o, 1'b1);

        // Random traffic against the model
        auto_set = 1'b1;
        rand_busy = 1'b1;
        spurious = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tb_job_t j;
            j = rjob();
            cmd_valid_i   = ($urandom_range(0, 1) == 1);
            cmd_central_i = j.c;
            cmd_radius_i  = j.r;
            cmd_mode_i    = j.m;
            res_ready_i   = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid_i = 1'b0;
        rand_busy = 1'b0;
        spurious = 1'b0;
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
